// File: rtl/video_pattern_gen_if.sv
// AXI4-Stream video bundle carried between the pattern source and its consumer.
// Only tready flows upstream; everything else is driven by the source.
interface video_pattern_gen_if #(
    parameter int DATA_W = 32
);
    logic              tvalid;
    logic              tready;
    logic [DATA_W-1:0] tdata;
    logic              tuser;
    logic              h_last;
    logic              v_last;

    modport master (
        output tvalid,
        output tdata,
        output tuser,
        output h_last,
        output v_last,
        input  tready
    );

    modport slave (
        input  tvalid,
        input  tdata,
        input  tuser,
        input  h_last,
        input  v_last,
        output tready
    );
endinterface

// File: rtl/video_pattern_gen.sv
// Parametrised AXI4-Stream video test-pattern source with blanking, backpressure,
// four runtime patterns and a completed-frame counter.
module video_pattern_gen #(
    parameter int H_ACTIVE     = 1280,
    parameter int V_ACTIVE     = 1024,
    parameter int H_BLANK      = 768,
    parameter int V_BLANK      = 2048,
    parameter int PIX_PER_BEAT = 4,
    parameter int PIX_W        = 8,
    parameter int V_SHIFT      = 2,
    parameter int H_SHIFT      = 2,
    parameter int CHK_SHIFT    = 5
) (
    input  logic                       data_clk,
    input  logic                       rst_n,
    input  logic                       enable,
    input  logic [1:0]                 mode,
    video_pattern_gen_if.master        axis,
    output logic [15:0]                frame_cnt
);

    localparam int BEATS     = H_ACTIVE / PIX_PER_BEAT;
    localparam int DATA_W    = PIX_PER_BEAT * PIX_W;
    localparam int BEAT_W    = (BEATS > 1) ? $clog2(BEATS) : 1;
    localparam int LINE_W    = (V_ACTIVE > 1) ? $clog2(V_ACTIVE) : 1;
    localparam int BLANK_MAX = (H_BLANK > V_BLANK) ? H_BLANK : V_BLANK;
    localparam int BLANK_W   = (BLANK_MAX > 1) ? $clog2(BLANK_MAX) : 1;

    localparam logic [BEAT_W-1:0]  BEAT_LAST    = BEAT_W'(BEATS - 1);
    localparam logic [LINE_W-1:0]  LINE_LAST    = LINE_W'(V_ACTIVE - 1);
    localparam logic [BLANK_W-1:0] H_BLANK_LAST = BLANK_W'((H_BLANK > 0) ? H_BLANK - 1 : 0);
    localparam logic [BLANK_W-1:0] V_BLANK_LAST = BLANK_W'((V_BLANK > 0) ? V_BLANK - 1 : 0);

    typedef enum logic [1:0] {
        ST_IDLE,
        ST_ACTIVE,
        ST_HBLANK,
        ST_VBLANK
    } state_t;

    state_t              state_q, state_d;
    logic [BEAT_W-1:0]   beat_q, beat_d;
    logic [LINE_W-1:0]   line_q, line_d;
    logic [BLANK_W-1:0]  blank_q, blank_d;
    logic [1:0]          mode_q, mode_d;
    logic [15:0]         frame_cnt_q, frame_cnt_d;

    logic                tvalid_q, tvalid_d;
    logic [DATA_W-1:0]   tdata_q, tdata_d;
    logic                tuser_q, tuser_d;
    logic                h_last_q, h_last_d;
    logic                v_last_q, v_last_d;

    logic                xfer;

    function automatic logic [PIX_W-1:0] pixel_value(
        input logic [1:0]  m,
        input logic [31:0] x,
        input logic [31:0] y,
        input logic [15:0] f
    );
        case (m)
            2'd0:    return PIX_W'(y >> V_SHIFT);
            2'd1:    return PIX_W'(x >> H_SHIFT);
            2'd2:    return {PIX_W{x[CHK_SHIFT] ^ y[CHK_SHIFT]}};
            default: return PIX_W'(x + y + 32'(f));
        endcase
    endfunction

    always_ff @(posedge data_clk or negedge rst_n) begin
        if (!rst_n) begin
            state_q     <= ST_IDLE;
            beat_q      <= '0;
            line_q      <= '0;
            blank_q     <= '0;
            mode_q      <= '0;
            frame_cnt_q <= '0;
            tvalid_q    <= 1'b0;
            tdata_q     <= '0;
            tuser_q     <= 1'b0;
            h_last_q    <= 1'b0;
            v_last_q    <= 1'b0;
        end else begin
            state_q     <= state_d;
            beat_q      <= beat_d;
            line_q      <= line_d;
            blank_q     <= blank_d;
            mode_q      <= mode_d;
            frame_cnt_q <= frame_cnt_d;
            tvalid_q    <= tvalid_d;
            tdata_q     <= tdata_d;
            tuser_q     <= tuser_d;
            h_last_q    <= h_last_d;
            v_last_q    <= v_last_d;
        end
    end

    // enable and mode are only looked at when a frame is about to begin.
    always_comb begin
        state_d     = state_q;
        beat_d      = beat_q;
        line_d      = line_q;
        blank_d     = blank_q;
        mode_d      = mode_q;
        frame_cnt_d = frame_cnt_q;
        xfer        = tvalid_q && axis.tready;

        case (state_q)
            ST_IDLE: begin
                if (enable) begin
                    state_d = ST_ACTIVE;
                    beat_d  = '0;
                    line_d  = '0;
                    mode_d  = mode;
                end
            end
            ST_ACTIVE: begin
                if (xfer) begin
                    if (beat_q != BEAT_LAST) begin
                        beat_d = beat_q + BEAT_W'(1);
                    end else begin
                        beat_d = '0;
                        if (line_q != LINE_LAST) begin
                            if (H_BLANK == 0) begin
                                line_d = line_q + LINE_W'(1);
                            end else begin
                                state_d = ST_HBLANK;
                                blank_d = '0;
                            end
                        end else begin
                            frame_cnt_d = frame_cnt_q + 16'd1;
                            line_d      = '0;
                            if (V_BLANK != 0) begin
                                state_d = ST_VBLANK;
                                blank_d = '0;
                            end else if (enable) begin
                                mode_d = mode;
                            end else begin
                                state_d = ST_IDLE;
                            end
                        end
                    end
                end
            end
            ST_HBLANK: begin
                if (blank_q == H_BLANK_LAST) begin
                    state_d = ST_ACTIVE;
                    line_d  = line_q + LINE_W'(1);
                end else begin
                    blank_d = blank_q + BLANK_W'(1);
                end
            end
            ST_VBLANK: begin
                if (blank_q == V_BLANK_LAST) begin
                    if (enable) begin
                        state_d = ST_ACTIVE;
                        mode_d  = mode;
                    end else begin
                        state_d = ST_IDLE;
                    end
                end else begin
                    blank_d = blank_q + BLANK_W'(1);
                end
            end
            default: begin
                state_d = ST_IDLE;
            end
        endcase
    end

    // Outputs are precomputed from next-state counters so every port is a flop;
    // a stalled beat naturally re-derives the same values and holds.
    always_comb begin
        tvalid_d = (state_d == ST_ACTIVE);
        tdata_d  = '0;
        tuser_d  = 1'b0;
        h_last_d = 1'b0;
        v_last_d = 1'b0;
        if (tvalid_d) begin
            tuser_d  = (beat_d == '0) && (line_d == '0);
            h_last_d = (beat_d == BEAT_LAST);
            v_last_d = (beat_d == BEAT_LAST) && (line_d == LINE_LAST);
            for (int k = 0; k < PIX_PER_BEAT; k++) begin
                tdata_d[k*PIX_W +: PIX_W] = pixel_value(
                    mode_d,
                    32'(beat_d) * 32'(PIX_PER_BEAT) + 32'(k),
                    32'(line_d),
                    frame_cnt_d);
            end
        end
    end

    assign axis.tvalid = tvalid_q;
    assign axis.tdata  = tdata_q;
    assign axis.tuser  = tuser_q;
    assign axis.h_last = h_last_q;
    assign axis.v_last = v_last_q;
    assign frame_cnt   = frame_cnt_q;

endmodule

// File: doc/video_pattern_gen.md
Name: video_pattern_gen

Overview:
- Parametrised sensor-stream pattern source. Successor to the fixed 1280x1024 gray-ramp generator.
- Emits AXI4-Stream video with configurable geometry, pixels per beat and pixel width, and horizontal/vertical blanking.
- Adds tready backpressure, a start-of-frame flag, four runtime-selectable patterns and a frame counter.
- Sits in front of the capture/DMA path as a bring-up and simulation data source.

Parameters:
- H_ACTIVE, 1280: active pixels per line; must be a multiple of PIX_PER_BEAT.
- V_ACTIVE, 1024: active lines per frame.
- H_BLANK, 768: idle cycles after each line (0 allowed).
- V_BLANK, 2048: idle cycles after each frame (0 allowed).
- PIX_PER_BEAT, 4: pixels per tdata beat (1..8).
- PIX_W, 8: bits per pixel (8..16).
- V_SHIFT, 2: right shift of line index for the vertical ramp.
- H_SHIFT, 2: right shift of pixel x for the horizontal ramp.
- CHK_SHIFT, 5: log2 of the checker square size.

Ports:
- data_clk  in  1  clock, all logic on rising edge.
- rst_n  in  1  asynchronous active-low reset.
- enable  in  1  run request, sampled at frame boundaries only.
- mode  in  2  pattern select, sampled at frame start.
- tready  in  1  downstream ready.
- tvalid  out  1  beat valid.
- tdata  out  PIX_PER_BEAT*PIX_W  pixels; lane k holds pixel x = beat*PIX_PER_BEAT+k (lane 0 = LSBs).
- tuser  out  1  start of frame: first beat of line 0.
- h_last  out  1  last beat of each line.
- v_last  out  1  last beat of the last line.
- frame_cnt  out  16  completed frames, wraps at 65535->0.

Behaviour:
- Reset (async assert, sync release): state IDLE; tvalid, tuser, h_last, v_last, tdata, frame_cnt all 0; internal beat/line/blank counters 0.
- States:
  - IDLE: if enable=1, latch mode into mode_q, clear beat/line counters, go to ACTIVE. First beat has tvalid=1 on the next edge (1-cycle latency).
  - ACTIVE: tvalid=1. A beat transfers when tvalid&&tready. On transfer of a non-last beat, advance to the next beat. On transfer of the last beat of a line (beat = H_ACTIVE/PIX_PER_BEAT-1):
    - if not the last line: go to HBLANK, or directly to the next line's ACTIVE if H_BLANK=0;
    - if the last line: go to VBLANK, or IDLE-equivalent decision if V_BLANK=0.
  - HBLANK: tvalid=0 for exactly H_BLANK cycles, then ACTIVE with line+1.
  - VBLANK: tvalid=0 for exactly V_BLANK cycles. Then, if enable=1, start the next frame directly (re-latch mode, no extra IDLE cycle); else go to IDLE.
- Blanking counts clock cycles and ignores tready.
- AXI rule: while tvalid=1 and tready=0, tdata/tuser/h_last/v_last hold stable. tvalid never drops without a transfer.
- enable deasserted mid-frame: the current frame completes including VBLANK, then IDLE. No partial frames.
- mode changes mid-frame are ignored until the next frame start.
- frame_cnt increments by 1 in the cycle the v_last beat transfers.
- Flags: tuser=1 only on beat 0 of line 0. h_last on every line's last beat. v_last only when both last line and last beat. All three may be high together when V_ACTIVE=1 and H_ACTIVE=PIX_PER_BEAT.
- Pixel value per lane, with x = pixel column, y = line, result truncated to PIX_W bits:
  - mode 0, vertical ramp: y>>V_SHIFT.
  - mode 1, horizontal ramp: x>>H_SHIFT.
  - mode 2, checker: all-ones if ((x>>CHK_SHIFT) xor (y>>CHK_SHIFT)) bit0 = 1, else 0.
  - mode 3, moving diagonal: x + y + frame_cnt.
- All outputs are registered. No combinational path from tready to any output other than through registers.
- Counter widths: sized by $clog2 of each parameter, minimum 1 bit.

Test Plan:
(Bench parameters: H_ACTIVE=16, PIX_PER_BEAT=4, PIX_W=8, V_ACTIVE=4, H_BLANK=3, V_BLANK=5, V_SHIFT=0, H_SHIFT=0, CHK_SHIFT=2.)
- mode=0, enable=1, tready=1 -> 16 beats per frame. Line 2 beats are 0x02020202. tuser on beat 0 only; h_last on beats 3/7/11/15; v_last on beat 15. tvalid low exactly 3 cycles between lines and 5 after the frame. frame_cnt goes 0->1.
- mode=1, tready=1 -> every line's beats are 0x03020100, 0x07060504, 0x0B0A0908, 0x0F0E0D0C.
- mode=1, tready toggled pseudo-randomly -> the same 16-beat sequence is received. tdata and flags stay stable during every stall. No beat is lost or duplicated.
- mode=2 -> line 0 beat 1 = 0xFFFFFFFF, line 0 beat 0 = 0x00000000, line 1 beat 1 = 0xFFFFFFFF. mode switched to 0 mid-frame -> the pattern changes only at the next tuser.
- enable dropped during line 1 -> the frame finishes through v_last and 5 VBLANK cycles, then tvalid stays 0. frame_cnt is 1.
- rst_n pulsed low mid-line, asynchronously -> tvalid and frame_cnt are 0 immediately. After release with enable=1, the next beat carries tuser=1 at line 0.
